// File: rtl/issue_queue_param_pkg.sv
// rtl/issue_queue_param_pkg.sv - shared sizing defaults for the parametrised issue queue
package issue_queue_param_pkg;

    localparam int NUM_IQ_ENTRIES      = 8;
    localparam int NUM_IQ_ENTRIES_LOG2 = $clog2(NUM_IQ_ENTRIES);
    localparam int IQ_ENTRY_SIZE       = 64;

    typedef struct packed {
        logic found0;
        logic found1;
    } iq_found_t;

endpackage

// File: rtl/iq_find_free.sv
// rtl/iq_find_free.sv - returns the two lowest set bits of a vector with found flags
module iq_find_free #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx0_o,
    output logic          found0_o,
    output logic [IW-1:0] idx1_o,
    output logic          found1_o
);

    logic [N-1:0]  rest;
    logic [IW-1:0] first_idx;
    logic          first_found;
    logic [IW-1:0] second_idx;
    logic          second_found;

    // Scanning downward lets the lowest set bit be the last (winning) assignment.
    always_comb begin
        first_idx    = '0;
        first_found  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                first_idx   = IW'(i);
                first_found = 1'b1;
            end
        end
        rest = vec_i;
        if (first_found) begin
            rest[first_idx] = 1'b0;
        end
        second_idx   = '0;
        second_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rest[i]) begin
                second_idx   = IW'(i);
                second_found = 1'b1;
            end
        end
    end

    assign idx0_o   = first_idx;
    assign found0_o = first_found;
    assign idx1_o   = second_idx;
    assign found1_o = second_found;

endmodule

// File: rtl/issue_queue_param.sv
// rtl/issue_queue_param.sv - dual push/pop issue queue with age matrix; option IQ_SAME_CYCLE_REUSE_EN
module issue_queue_param
    import issue_queue_param_pkg::*;
#(
    parameter  int DEPTH = NUM_IQ_ENTRIES,
    parameter  int WIDTH = IQ_ENTRY_SIZE,
    localparam int KEY_W = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   push0_i,
    input  logic [WIDTH-1:0]       push_data0_i,
    output logic                   push_ack0_o,
    input  logic                   push1_i,
    input  logic [WIDTH-1:0]       push_data1_i,
    output logic                   push_ack1_o,
    input  logic                   pop0_i,
    input  logic [KEY_W-1:0]       pop_key0_i,
    input  logic                   pop1_i,
    input  logic [KEY_W-1:0]       pop_key1_i,
    output logic [DEPTH-1:0]       valid_o,
    output logic [DEPTH*WIDTH-1:0] data_o,
    output logic [KEY_W:0]         count_o,
    output logic [KEY_W:0]         free_o,
    output logic                   oldest_valid_o,
    output logic [KEY_W-1:0]       oldest_key_o
);

    localparam int CW = KEY_W + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    free_q, free_d;

    logic [DEPTH-1:0] popped;
    logic [DEPTH-1:0] avail;
    logic [KEY_W-1:0] idx0, idx1, slot0, slot1;
    iq_found_t        found;
    logic             ack0, ack1;
    logic [CW-1:0]    npop;
    logic [KEY_W-1:0] oldest_key;
    logic             blocked;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            popped[j] = valid_q[j] &
                        ((pop0_i & (pop_key0_i == KEY_W'(j))) |
                         (pop1_i & (pop_key1_i == KEY_W'(j))));
        end
    end

`ifdef IQ_SAME_CYCLE_REUSE_EN
    assign avail = ~valid_q | popped;
`else
    assign avail = ~valid_q;
`endif

    iq_find_free #(.N(DEPTH)) u_find_free (
        .vec_i    (avail),
        .idx0_o   (idx0),
        .found0_o (found.found0),
        .idx1_o   (idx1),
        .found1_o (found.found1)
    );

    // push1 falls back to the lowest slot only when push0 is idle.
    assign ack0  = push0_i & found.found0 & ~flush_i & ~reset_i;
    assign ack1  = push1_i & ~flush_i & ~reset_i &
                   (found.found1 | (~push0_i & found.found0));
    assign slot0 = idx0;
    assign slot1 = push0_i ? idx1 : idx0;

    assign push_ack0_o = ack0;
    assign push_ack1_o = ack1;

    always_comb begin
        valid_d = valid_q & ~popped;
        npop    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            older_d[i] = older_q[i];
            npop       = npop + CW'(popped[i]);
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (popped[j]) begin
                older_d[j] = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    older_d[i][j] = 1'b0;
                end
            end
        end
        if (ack0) begin
            valid_d[slot0] = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                older_d[j][slot0] = valid_q[j] & ~popped[j];
            end
            older_d[slot0] = '0;
        end
        if (ack1) begin
            valid_d[slot1] = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                older_d[j][slot1] = valid_q[j] & ~popped[j];
            end
            older_d[slot1] = '0;
            if (ack0) begin
                older_d[slot0][slot1] = 1'b1;
            end
        end
        count_d = count_q - npop + CW'(ack0) + CW'(ack1);
        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_d[i] = '0;
            end
        end
        free_d = CW'(DEPTH) - count_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            count_q <= '0;
            free_q  <= CW'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            free_q  <= free_d;
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ack0) begin
            data_q[slot0] <= push_data0_i;
        end
        if (ack1) begin
            data_q[slot1] <= push_data1_i;
        end
    end

    // Oldest entry: the valid one that no other valid entry claims to be older than.
    always_comb begin
        oldest_key = '0;
        blocked    = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                blocked = blocked | (valid_q[j] & older_q[j][i]);
            end
            if (valid_q[i] && !blocked) begin
                oldest_key = KEY_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_o[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

    assign valid_o        = valid_q;
    assign count_o        = count_q;
    assign free_o         = free_q;
    assign oldest_valid_o = |valid_q;
    assign oldest_key_o   = oldest_key;

endmodule

// File: tb/tb_issue_queue_param.sv
// tb/tb_issue_queue_param.sv - randomized self-checking bench with an allocation-order reference model
module tb_issue_queue_param;

    localparam int DEPTH = 8;
    localparam int WIDTH = 64;
    localparam int KEY_W = 3;

    logic                   clk = 1'b0;
    logic                   reset_i, flush_i;
    logic                   push0_i, push1_i, pop0_i, pop1_i;
    logic [WIDTH-1:0]       push_data0_i, push_data1_i;
    logic [KEY_W-1:0]       pop_key0_i, pop_key1_i;
    logic                   push_ack0_o, push_ack1_o;
    logic [DEPTH-1:0]       valid_o;
    logic [DEPTH*WIDTH-1:0] data_o;
    logic [KEY_W:0]         count_o, free_o;
    logic                   oldest_valid_o;
    logic [KEY_W-1:0]       oldest_key_o;

    issue_queue_param #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .flush_i        (flush_i),
        .push0_i        (push0_i),
        .push_data0_i   (push_data0_i),
        .push_ack0_o    (push_ack0_o),
        .push1_i        (push1_i),
        .push_data1_i   (push_data1_i),
        .push_ack1_o    (push_ack1_o),
        .pop0_i         (pop0_i),
        .pop_key0_i     (pop_key0_i),
        .pop1_i         (pop1_i),
        .pop_key1_i     (pop_key1_i),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .count_o        (count_o),
        .free_o         (free_o),
        .oldest_valid_o (oldest_valid_o),
        .oldest_key_o   (oldest_key_o)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    bit               m_valid [DEPTH];
    logic [WIDTH-1:0] m_data  [DEPTH];
    int               m_order [$];
    bit               e_ack0, e_ack1;
    int               e_slot0, e_slot1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_popped(input int k);
        return m_valid[k] && ((pop0_i && pop_key0_i == k) || (pop1_i && pop_key1_i == k));
    endfunction

    task automatic model_acks();
        int av[$];
        for (int i = 0; i < DEPTH; i++) begin
`ifdef IQ_SAME_CYCLE_REUSE_EN
            if (!m_valid[i] || m_popped(i)) av.push_back(i);
`else
            if (!m_valid[i]) av.push_back(i);
`endif
        end
        e_ack0  = push0_i && !flush_i && av.size() > 0;
        e_ack1  = push1_i && !flush_i && (av.size() >= 2 || (!push0_i && av.size() > 0));
        e_slot0 = e_ack0 ? av[0] : 0;
        e_slot1 = e_ack1 ? (e_ack0 ? av[1] : av[0]) : 0;
    endtask

    task automatic model_remove(input int k);
        for (int i = 0; i < m_order.size(); i++) begin
            if (m_order[i] == k) begin
                m_order.delete(i);
                break;
            end
        end
        m_valid[k] = 1'b0;
    endtask

    task automatic model_reset();
        m_order.delete();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_commit();
        if (flush_i) begin
            model_reset();
            return;
        end
        if (pop0_i && m_valid[pop_key0_i]) model_remove(int'(pop_key0_i));
        if (pop1_i && m_valid[pop_key1_i]) model_remove(int'(pop_key1_i));
        if (e_ack0) begin
            m_valid[e_slot0] = 1'b1;
            m_data[e_slot0]  = push_data0_i;
            m_order.push_back(e_slot0);
        end
        if (e_ack1) begin
            m_valid[e_slot1] = 1'b1;
            m_data[e_slot1]  = push_data1_i;
            m_order.push_back(e_slot1);
        end
    endtask

    task automatic check_state();
        logic [DEPTH-1:0] ev;
        for (int i = 0; i < DEPTH; i++) ev[i] = m_valid[i];
        check("valid", 64'(valid_o), 64'(ev));
        check("count", 64'(count_o), 64'(m_order.size()));
        check("free", 64'(free_o), 64'(DEPTH - m_order.size()));
        check("oldest_valid", 64'(oldest_valid_o), 64'(m_order.size() > 0));
        if (m_order.size() > 0) check("oldest_key", 64'(oldest_key_o), 64'(m_order[0]));
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i]) check($sformatf("data%0d", i), data_o[i*WIDTH +: WIDTH], m_data[i]);
        end
    endtask

    task automatic cycle(input bit p0, input logic [WIDTH-1:0] d0, input bit p1,
                         input logic [WIDTH-1:0] d1, input bit q0, input int k0,
                         input bit q1, input int k1, input bit fl);
        @(negedge clk);
        push0_i = p0; push_data0_i = d0; push1_i = p1; push_data1_i = d1;
        pop0_i = q0; pop_key0_i = KEY_W'(k0); pop1_i = q1; pop_key1_i = KEY_W'(k1);
        flush_i = fl;
        #1;
        model_acks();
        check("ack0", 64'(push_ack0_o), 64'(e_ack0));
        check("ack1", 64'(push_ack1_o), 64'(e_ack1));
        @(posedge clk);
        model_commit();
        #1;
        check_state();
    endtask

    task automatic idle_inputs();
        push0_i = 0; push1_i = 0; pop0_i = 0; pop1_i = 0; flush_i = 0;
        push_data0_i = '0; push_data1_i = '0; pop_key0_i = '0; pop_key1_i = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_free", 64'(free_o), 64'd8);
        check("rst_oldest_valid", 64'(oldest_valid_o), 64'd0);
        check("rst_oldest_key", 64'(oldest_key_o), 64'd0);
        check("rst_ack0", 64'(push_ack0_o), 64'd0);
        check("rst_ack1", 64'(push_ack1_o), 64'd0);
    endtask

    initial begin
        idle_inputs();
        reset_i = 1'b1;
        push0_i = 1'b1; push1_i = 1'b1;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        idle_inputs();
        reset_i = 1'b0;

        for (int c = 0; c < 4; c++) cycle(1, 64'd15, 1, 64'd255, 0, 0, 0, 0, 0);
        check("fill_count", 64'(count_o), 64'd8);
        check("fill_free", 64'(free_o), 64'd0);
        check("fill_oldest", 64'(oldest_key_o), 64'd0);
        check("fill_data7", data_o[7*WIDTH +: WIDTH], 64'd255);

        cycle(1, 64'hABCD, 0, 0, 1, 3, 0, 0, 0);
`ifdef IQ_SAME_CYCLE_REUSE_EN
        check("reuse_count", 64'(count_o), 64'd8);
        check("reuse_data3", data_o[3*WIDTH +: WIDTH], 64'hABCD);
`else
        check("full_pop_count", 64'(count_o), 64'd7);
`endif
        cycle(1, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
        check("refill_count", 64'(count_o), 64'd8);

        cycle(0, 0, 0, 0, 1, 0, 1, 0, 0);
        check("dup_pop_count", 64'(count_o), 64'd7);
        check("dup_pop_oldest", 64'(oldest_key_o), 64'd1);

        cycle(1, 64'h77, 1, 64'h88, 0, 0, 0, 0, 0);
        check("free1_count", 64'(count_o), 64'd8);

        cycle(0, 0, 0, 0, 1, 1, 1, 2, 0);
        cycle(0, 0, 0, 0, 1, 4, 0, 0, 0);
        check("five_count", 64'(count_o), 64'd5);
        cycle(1, 64'h99, 0, 0, 1, 5, 0, 0, 1);
        check("flush_valid", 64'(valid_o), 64'd0);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_free", 64'(free_o), 64'd8);
        check("flush_oldest_valid", 64'(oldest_valid_o), 64'd0);

        for (int c = 0; c < 400; c++) begin
            int k0, k1;
            k0 = $urandom_range(DEPTH - 1);
            k1 = $urandom_range(DEPTH - 1);
            if (m_order.size() > 0 && $urandom_range(1)) k0 = m_order[$urandom_range(m_order.size() - 1)];
            if (m_order.size() > 0 && $urandom_range(1)) k1 = m_order[$urandom_range(m_order.size() - 1)];
            cycle($urandom_range(9) < 6, {$urandom, $urandom}, $urandom_range(9) < 6,
                  {$urandom, $urandom}, $urandom_range(9) < 4, k0,
                  $urandom_range(9) < 3, k1, $urandom_range(31) == 0);
        end

        cycle(1, 64'h5, 1, 64'h6, 0, 0, 0, 0, 0);
        @(negedge clk);
        push0_i = 1'b1; push1_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge clk);
        check_reset_outputs();
        idle_inputs();
        reset_i = 1'b0;
        for (int c = 0; c < 4; c++) cycle(1, 64'(c), 1, 64'(c + 100), 0, 0, 0, 0, 0);
        check("resume_count", 64'(count_o), 64'd8);
        check("resume_oldest", 64'(oldest_key_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/issue_queue_param.md
Name: issue_queue_param

Overview:
Parametrised successor to the fixed 8-entry issue queue: DEPTH entries of WIDTH-bit payload, two push ports, two pop-by-key ports, and flush. New over the previous generation:
- push acknowledge / backpressure;
- per-entry valid vector;
- age-matrix tracking that reports the oldest valid entry to the select logic.

Sits between rename/dispatch (push side) and the issue-select stage (pop side).

Parameters:
DEPTH, 8, number of entries (power of two, >=2)
WIDTH, 64, payload bits per entry (defaults to `IQ_ENTRY_SIZE)
KEY_W, $clog2(DEPTH), entry index width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  invalidate all entries at next edge
push0  in  1  push request, port 0 (older of the pair)
push_data0  in  WIDTH  payload, port 0
push_ack0  out  1  push0 accepted this cycle
push1  in  1  push request, port 1
push_data1  in  WIDTH  payload, port 1
push_ack1  out  1  push1 accepted this cycle
pop0  in  1  free entry pop_key0
pop_key0  in  KEY_W  entry index
pop1  in  1  free entry pop_key1
pop_key1  in  KEY_W  entry index
valid  out  DEPTH  per-entry valid bits
data  out  DEPTH*WIDTH  flattened payloads; entry i at [i*WIDTH +: WIDTH]
count  out  KEY_W+1  valid entries
free  out  KEY_W+1  DEPTH - count
oldest_valid  out  1  at least one entry valid
oldest_key  out  KEY_W  index of oldest valid entry

Behaviour:
- Reset (async, any time, including mid-operation):
  - valid=0, age matrix=0, count=0, free=DEPTH.
  - oldest_valid=0, oldest_key=0, push_ack0/1=0.
  - Payload registers not reset.
- State: valid[DEPTH], data[DEPTH], age matrix older[i][j] (1 = entry i older than entry j); all registered.
- count and free are registered, updated at the same edge as valid.
- Free slot set avail = ~valid (registered state). Same-cycle pops do not contribute unless IQ_SAME_CYCLE_REUSE_EN.
- push_ack (combinational from registered state and current push/flush):
  - push_ack0 = push0 & |avail & ~flush.
  - push_ack1 = push1 & ~flush & (avail has >=2 bits set, or push0=0 and avail nonzero).
  - Unacknowledged pushes are dropped. Producer holds and retries.
- Allocation:
  - push0 takes the lowest-index available slot.
  - push1 takes the next lowest available slot, or the lowest if push0 is not accepted.
  - Write data, set valid at the edge. Latency 1: entry visible on valid/data the cycle after ack.
- Age update on allocating slot k: older[j][k] = valid[j] & ~popped[j] for all j; older[k][*] = 0. If both ports allocate, the push0 slot is marked older than the push1 slot.
- Pop:
  - Clears valid[pop_key] at the edge.
  - Popping an invalid entry: no effect, count unchanged.
  - pop0 and pop1 with the same key: single decrement.
  - Popped slot's older row and column are cleared.
- Flush: next edge valid=0, count=0, free=DEPTH, age matrix cleared. Overrides all pushes and pops that cycle (acks forced 0).
- Oldest: combinational from registers. oldest_key = the unique valid i with no valid j where older[j][i]=1. Reported independent of same-cycle pops.
- count update: count_next = count - pops_effective + pushes_accepted (never negative, never above DEPTH).
- Full: free=0, so both acks=0. A push in the same cycle as a pop still gets no ack, except under the option.

Optional Feature:
IQ_SAME_CYCLE_REUSE_EN:
- Defined: avail = ~valid | popped_this_cycle, so a slot popped this cycle may be reallocated by a same-cycle push. Write wins over the clear, the new age row is applied, and the new entry is youngest.
- Undefined: popped slots become available the following cycle (base behaviour above).

Decomposition:
- defines.vh carries NUM_IQ_ENTRIES, NUM_IQ_ENTRIES_LOG2, IQ_ENTRY_SIZE as parameter defaults, plus the macro.
- One sub-module, iq_find_free: priority encoder returning the first two set bits of a DEPTH-wide vector with found flags. Used for allocation.
- Oldest search is inline.

Test Plan:
- Reset, then push0=1 data 15 and push1=1 data 255 for 4 cycles (8 entries): acks high for all 4 cycles; slots filled 0..7 with 15,255 alternating; count=8, free=0; oldest_key=0.
- Full queue, push0=1, pop0=1 key 3: ack0=0, count=7. With IQ_SAME_CYCLE_REUSE_EN: ack0=1, slot 3 rewritten, count=8, slot 3 youngest.
- Full queue, pop0 key 0 and pop1 key 0 simultaneously: count=7; oldest_key becomes 1.
- Free=1, push0 and push1 both asserted: ack0=1, ack1=0; count=8.
- 5 entries valid, assert flush with push0 and pop0 active: acks 0; next cycle valid=0, count=0, free=8, oldest_valid=0.
- Assert reset mid-stream with pushes pending: outputs go to reset values immediately without a clock edge; normal fill resumes after deassert.
